instr_encoder: RTL and testbench

//  Inverse of the pipeline's instruction decoder: accepts symbolic instruction requests
//  (op select + register/immediate fields), encodes them into 32-bit MIPS words, buffers

---
 rtl/instr_encoder.sv | 138 +++++++++++++
 tb/tb_instr_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Symbolic instruction request -> 32-bit MIPS word encoder with a small FIFO that
// streams the encoded words into instruction memory at consecutive word addresses.
module instr_encoder #(
   parameter int                DEPTH  = 4,
   parameter int                ADDR_W = 10,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [25:0]       in_imm,
   input  logic              addr_clr,
   input  logic              im_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic [ADDR_W:0]   count,
   output logic              bad_op
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   // Unused fields stay zero; lui ignores rs; illegal (15) encodes to zero but is never stored.
   function automatic logic [31:0] encode(
      input logic [3:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [25:0] imm
   );
      logic [31:0] w;
      case (op)
         4'd0:    w = 32'h0000_0000;
         4'd1:    w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
         4'd2:    w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
         4'd3:    w = {6'h00, rs, 15'd0, 6'h08};
         4'd4:    w = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
         4'd5:    w = {6'h08, rs, rt, imm[15:0]};
         4'd6:    w = {6'h0D, rs, rt, imm[15:0]};
         4'd7:    w = {6'h0F, 5'd0, rt, imm[15:0]};
         4'd8:    w = {6'h23, rs, rt, imm[15:0]};
         4'd9:    w = {6'h20, rs, rt, imm[15:0]};
         4'd10:   w = {6'h2B, rs, rt, imm[15:0]};
         4'd11:   w = {6'h28, rs, rt, imm[15:0]};
         4'd12:   w = {6'h04, rs, rt, imm[15:0]};
         4'd13:   w = {6'h03, imm};
         4'd14:   w = {6'h02, imm};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   logic [31:0]       mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   count_r;
   logic              bad_op_r;
   logic              full_s;
   logic              empty_s;
   logic              accept_s;
   logic              illegal_s;
   logic              push_s;
   logic              pop_s;
   logic [31:0]       enc_s;

   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                      (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
   assign in_ready  = !full_s;
   assign accept_s  = in_valid && !full_s;
   assign illegal_s = (in_op == 4'd15);
   assign push_s    = accept_s && !illegal_s;
   assign pop_s     = !empty_s && im_ready;

   assign im_we    = pop_s;
   assign im_addr  = addr_r;
   assign im_wdata = mem_r[rd_ptr_r[IDX_W-1:0]];
   assign count    = count_r;
   assign bad_op   = bad_op_r;

   // Encode the request currently presented on the input fields.
   always_comb begin
      enc_s = encode(in_op, in_rs, in_rt, in_rd, in_imm);
   end

   // FIFO storage and pointers; occupancy holds on simultaneous push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= enc_s;
            wr_ptr_r                   <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
      end
   end

   // Write address and saturating word count; addr_clr wins over the increment of a same-cycle write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_r  <= BASE;
         count_r <= '0;
      end else if (addr_clr) begin
         addr_r  <= BASE;
         count_r <= '0;
      end else if (pop_s) begin
         addr_r <= addr_r + 1'b1;
         if (count_r != COUNT_MAX) begin
            count_r <= count_r + 1'b1;
         end
      end
   end

   // Sticky flag for any accepted illegal request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bad_op_r <= 1'b0;
      end else if (accept_s && illegal_s) begin
         bad_op_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at accept and
// compared, together with the expected IM address, whenever the DUT writes.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [25:0] in_imm;
   logic        addr_clr;
   logic        im_ready;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [31:0] im_wdata;
   logic [10:0] count;
   logic        bad_op;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cur_exp;
   logic [9:0]  m_addr;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE(10'd0)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .addr_clr(addr_clr), .im_ready(im_ready), .im_we(im_we), .im_addr(im_addr),
      .im_wdata(im_wdata), .count(count), .bad_op(bad_op)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard: sample 3 time units after the falling edge, well before the rising edge.
   always begin
      logic [31:0] e;
      @(negedge clk);
      #3;
      if (reset_n) begin
         if (im_we) begin
            if (!im_ready) check_eq("we_without_ready", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
               check_eq("spurious_write", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("wdata", im_wdata, e);
            end
            check_eq("im_addr", {22'd0, im_addr}, {22'd0, m_addr});
            m_addr = m_addr + 10'd1;
         end
         if (addr_clr) m_addr = 10'd0;
         if (in_valid && in_ready && in_op != 4'd15) exp_q.push_back(cur_exp);
      end
   end

   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, input logic [31:0] exp);
      int   waited = 0;
      logic acc    = 1'b0;
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      cur_exp  = exp;
      in_valid = 1'b1;
      while (!acc) begin
         #3 acc = in_ready;
         @(negedge clk);
         if (!acc) begin
            waited++;
            if (waited > 200) begin
               check_eq("send_timeout", 32'd0, 32'd1);
               acc = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0;
      in_rd = 5'd0; in_imm = 26'd0; addr_clr = 1'b0; im_ready = 1'b1;
      cur_exp = 32'd0; m_addr = 10'd0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_im_we", {31'd0, im_we}, 32'd0);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_addr", {22'd0, im_addr}, 32'd0);
      check_eq("rst_count", {21'd0, count}, 32'd0);
      check_eq("rst_bad_op", {31'd0, bad_op}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: addu, no bypass then written next cycle
      in_op = 4'd1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_imm = 26'd0;
      cur_exp = 32'h0022_1821; in_valid = 1'b1;
      #3 check_eq("no_bypass", {31'd0, im_we}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #3 check_eq("latency_n1", {31'd0, im_we}, 32'd1);
      @(negedge clk);

      // 2: I-types, lui with nonzero rs must drop it
      send(4'd6, 5'd0, 5'd1, 5'd0, 26'h0001234, 32'h3401_1234);
      send(4'd7, 5'd7, 5'd2, 5'd0, 26'h000ABCD, 32'h3C02_ABCD);
      send(4'd10, 5'd0, 5'd5, 5'd0, 26'h0000004, 32'hAC05_0004);
      // 3: branch/jumps, jr with junk rt/rd
      send(4'd12, 5'd1, 5'd2, 5'd0, 26'h000FFFF, 32'h1022_FFFF);
      send(4'd13, 5'd0, 5'd0, 5'd0, 26'h0000C00, 32'h0C00_0C00);
      send(4'd3, 5'd31, 5'd9, 5'd9, 26'h0, 32'h03E0_0008);
      drain();
      #3;
      check_eq("count_after7", {21'd0, count}, 32'd7);
      check_eq("addr_after7", {22'd0, im_addr}, 32'd7);
      @(negedge clk);

      // remaining ops, nop with junk fields
      send(4'd0, 5'd3, 5'd4, 5'd5, 26'h3FFFFFF, 32'h0000_0000);
      send(4'd5, 5'd0, 5'd1, 5'd0, 26'h0000007, 32'h2001_0007);
      send(4'd14, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 32'h0BFF_FFFF);
      drain();

      // 4: fill while IM stalled; fifth waits until a pop frees a slot
      im_ready = 1'b0;
      send(4'd2, 5'd5, 5'd6, 5'd4, 26'h0, 32'h00A6_2023);
      send(4'd4, 5'd4, 5'd0, 5'd31, 26'h0, 32'h0080_F809);
      send(4'd8, 5'd29, 5'd8, 5'd0, 26'h0000010, 32'h8FA8_0010);
      send(4'd9, 5'd4, 5'd9, 5'd0, 26'h000FFFC, 32'h8089_FFFC);
      #3 check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      fork
         send(4'd11, 5'd2, 5'd3, 5'd0, 26'h0000001, 32'hA043_0001);
         begin
            repeat (3) @(negedge clk);
            im_ready = 1'b1;
            #3 check_eq("ready_indep_of_pop", {31'd0, in_ready}, 32'd0);
         end
      join
      drain();

      // 5: illegal op is swallowed, flag sticks; addr_clr during a write
      send(4'd15, 5'd1, 5'd1, 5'd1, 26'h1, 32'h0);
      repeat (3) @(negedge clk);
      #3 check_eq("bad_op_set", {31'd0, bad_op}, 32'd1);
      @(negedge clk);
      im_ready = 1'b0;
      send(4'd5, 5'd0, 5'd1, 5'd0, 26'h0000007, 32'h2001_0007);
      send(4'd0, 5'd0, 5'd0, 5'd0, 26'h0, 32'h0000_0000);
      addr_clr = 1'b1; im_ready = 1'b1;
      @(negedge clk);
      addr_clr = 1'b0;
      drain();
      #3;
      check_eq("count_after_clr", {21'd0, count}, 32'd1);
      check_eq("addr_after_clr", {22'd0, im_addr}, 32'd1);
      check_eq("bad_op_held", {31'd0, bad_op}, 32'd1);
      @(negedge clk);

      // 6: reset with two entries queued
      im_ready = 1'b0;
      send(4'd0, 5'd0, 5'd0, 5'd0, 26'h0, 32'h0);
      send(4'd1, 5'd1, 5'd2, 5'd3, 26'h0, 32'h0022_1821);
      #1;
      im_ready = 1'b1; reset_n = 1'b0;
      exp_q.delete(); m_addr = 10'd0;
      #1;
      check_eq("arst_im_we", {31'd0, im_we}, 32'd0);
      check_eq("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("arst_count", {21'd0, count}, 32'd0);
      check_eq("arst_addr", {22'd0, im_addr}, 32'd0);
      check_eq("arst_bad_op", {31'd0, bad_op}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // address wrap and count saturation
      for (int i = 0; i < 1030; i++) begin
         send(4'd5, 5'd0, 5'd1, 5'd0, {10'd0, i[15:0]}, 32'h2001_0000 | {16'd0, i[15:0]});
      end
      drain();
      #3;
      check_eq("count_sat", {21'd0, count}, 32'd1024);
      check_eq("addr_wrap", {22'd0, im_addr}, 32'd6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
